// File: rtl/rmt_ingress_arbiter_if.sv
// rtl/rmt_ingress_arbiter_if.sv - AXI-Stream bundle used for the arbiter ingress and egress ports
interface rmt_ingress_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_ingress_arbiter.sv
// rtl/rmt_ingress_arbiter.sv - two-port packet round-robin AXI-Stream merger with source tagging
module rmt_ingress_arbiter #(
  parameter int              C_S_AXIS_DATA_WIDTH  = 512,
  parameter int              C_S_AXIS_TUSER_WIDTH = 128,
  parameter int              SRC_PORT_LSB         = 16,
  parameter logic [7:0]      PORT0_TAG            = 8'h01,
  parameter logic [7:0]      PORT1_TAG            = 8'h04
) (
  input  logic                   clk,
  input  logic                   areset,
  rmt_ingress_arbiter_if.slave   s0_axis,
  rmt_ingress_arbiter_if.slave   s1_axis,
  rmt_ingress_arbiter_if.master  m_axis,
  output logic [31:0]            pkt_cnt_0,
  output logic [31:0]            pkt_cnt_1
);
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, PKT0 = 2'd1, PKT1 = 2'd2} state_e;

  state_e                            state_q, state_d;
  logic                              prio_q, prio_d;
  logic                              m_valid_q, m_valid_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [KEEP_W-1:0]                 m_keep_q, m_keep_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_user_q, m_user_d;
  logic                              m_last_q, m_last_d;
  logic [31:0]                       pkt_cnt0_q, pkt_cnt0_d;
  logic [31:0]                       pkt_cnt1_q, pkt_cnt1_d;
  logic                              out_free, acc0, acc1;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_user_q   <= '0;
      m_last_q   <= 1'b0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_user_q   <= m_user_d;
      m_last_q   <= m_last_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  // Grant is held for the whole packet; prio flips only on a granted tlast.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    case (state_q)
      IDLE: begin
        if (s0_axis.tvalid && (!s1_axis.tvalid || !prio_q)) state_d = PKT0;
        else if (s1_axis.tvalid)                            state_d = PKT1;
      end
      PKT0: begin
        if (acc0 && s0_axis.tlast) begin
          state_d    = IDLE;
          prio_d     = 1'b1;
          pkt_cnt0_d = pkt_cnt0_q + 32'd1;
        end
      end
      PKT1: begin
        if (acc1 && s1_axis.tlast) begin
          state_d    = IDLE;
          prio_d     = 1'b0;
          pkt_cnt1_d = pkt_cnt1_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_free       = !m_valid_q || m_axis.tready;
    s0_axis.tready = (state_q == PKT0) && out_free;
    s1_axis.tready = (state_q == PKT1) && out_free;
    acc0           = s0_axis.tready && s0_axis.tvalid;
    acc1           = s1_axis.tready && s1_axis.tvalid;
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    if (acc0) begin
      m_valid_d = 1'b1;
      m_data_d  = s0_axis.tdata;
      m_keep_d  = s0_axis.tkeep;
      m_last_d  = s0_axis.tlast;
      m_user_d  = s0_axis.tuser;
      m_user_d[SRC_PORT_LSB +: 8] = PORT0_TAG;
    end else if (acc1) begin
      m_valid_d = 1'b1;
      m_data_d  = s1_axis.tdata;
      m_keep_d  = s1_axis.tkeep;
      m_last_d  = s1_axis.tlast;
      m_user_d  = s1_axis.tuser;
      m_user_d[SRC_PORT_LSB +: 8] = PORT1_TAG;
    end else if (m_valid_q && m_axis.tready) begin
      m_valid_d = 1'b0;
    end
  end

  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tuser  = m_user_q;
  assign m_axis.tlast  = m_last_q;
  assign pkt_cnt_0     = pkt_cnt0_q;
  assign pkt_cnt_1     = pkt_cnt1_q;
endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// tb/tb_rmt_ingress_arbiter.sv - scoreboard bench for the two-port ingress arbiter
module tb_rmt_ingress_arbiter;
  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic        clk;
  logic        areset;
  logic [31:0] pkt_cnt_0, pkt_cnt_1;

  rmt_ingress_arbiter_if #(.DATA_W(512), .USER_W(128)) s0_if ();
  rmt_ingress_arbiter_if #(.DATA_W(512), .USER_W(128)) s1_if ();
  rmt_ingress_arbiter_if #(.DATA_W(512), .USER_W(128)) m_if ();

  rmt_ingress_arbiter dut (
    .clk       (clk),
    .areset    (areset),
    .s0_axis   (s0_if.slave),
    .s1_axis   (s1_if.slave),
    .m_axis    (m_if.master),
    .pkt_cnt_0 (pkt_cnt_0),
    .pkt_cnt_1 (pkt_cnt_1)
  );

  beat_t q0[$], q1[$], exp_q[$];
  bit    have0, have1, hold0, hold1, acc0, acc1;
  bit    strict, have_prev, prev_last;
  int    cyc, prev_cyc, nout;
  int    n_vec, n_err;

  assign s0_if.tvalid = have0 && !hold0;
  assign s1_if.tvalid = have1 && !hold1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_pkt(input int port, input int nb, input bit ones);
    beat_t b, e;
    for (int i = 0; i < nb; i++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom();
      b.keep = {$urandom(), $urandom()};
      b.user = ones ? {128{1'b1}} : {$urandom(), $urandom(), $urandom(), $urandom()};
      b.last = (i == nb - 1);
      e = b;
      e.user[23:16] = (port == 0) ? 8'h01 : 8'h04;
      if (port == 0) q0.push_back(b);
      else           q1.push_back(b);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 300, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_out(input int target, input string tag);
    int n = 0;
    while (nout < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 100, 1);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    areset = 1'b0;
  endtask

  // Source drivers: present queue heads, retire a head after it was accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (q0.size() > 0) begin
        s0_if.tdata = q0[0].data; s0_if.tkeep = q0[0].keep;
        s0_if.tuser = q0[0].user; s0_if.tlast = q0[0].last;
        have0 = 1'b1;
      end else have0 = 1'b0;
      if (q1.size() > 0) begin
        s1_if.tdata = q1[0].data; s1_if.tkeep = q1[0].keep;
        s1_if.tuser = q1[0].user; s1_if.tlast = q1[0].last;
        have1 = 1'b1;
      end else have1 = 1'b0;
    end
  end

  // Output monitor and scoreboard compare.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      acc0 = s0_if.tvalid && s0_if.tready;
      acc1 = s1_if.tvalid && s1_if.tready;
      if (!areset && m_if.tvalid && m_if.tready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", m_if.tdata, e.data);
          chk("tkeep", m_if.tkeep, e.keep);
          chk("tuser", m_if.tuser, e.user);
          chk("tlast", m_if.tlast, e.last);
        end
        if (strict && have_prev) chk("beat_gap", cyc - prev_cyc, prev_last ? 2 : 1);
        prev_cyc  = cyc;
        prev_last = m_if.tlast;
        have_prev = 1'b1;
        nout++;
      end
    end
  end

  initial begin
    logic [511:0] cap_data;
    logic [127:0] cap_user;
    logic         cap_last;
    int           base;
    n_vec = 0; n_err = 0; cyc = 0; nout = 0;
    have0 = 0; have1 = 0; hold0 = 0; hold1 = 0; acc0 = 0; acc1 = 0;
    strict = 0; have_prev = 0; prev_last = 0; prev_cyc = 0;
    s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tuser = '0; s0_if.tlast = 1'b0;
    s1_if.tdata = '0; s1_if.tkeep = '0; s1_if.tuser = '0; s1_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    areset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_tuser", m_if.tuser, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_s0_tready", s0_if.tready, 0);
    chk("rst_s1_tready", s1_if.tready, 0);
    chk("rst_cnt0", pkt_cnt_0, 0);
    chk("rst_cnt1", pkt_cnt_1, 0);
    areset = 1'b0;
    @(negedge clk);

    // Single port: 3 x 4 beats, one idle cycle between packets
    strict = 1; have_prev = 0;
    for (int p = 0; p < 3; p++) push_pkt(0, 4, 0);
    drain("single_drain");
    strict = 0;
    chk("single_cnt0", pkt_cnt_0, 3);
    chk("single_cnt1", pkt_cnt_1, 0);

    // Contention: alternating grants starting with port 0
    do_reset();
    push_pkt(0, 2, 0); push_pkt(1, 2, 0); push_pkt(0, 2, 0); push_pkt(1, 2, 0);
    drain("cont_drain");
    chk("cont_cnt0", pkt_cnt_0, 2);
    chk("cont_cnt1", pkt_cnt_1, 2);

    // Backpressure mid-packet
    base = nout;
    push_pkt(0, 4, 0);
    wait_out(base + 2, "bp_wait");
    @(posedge clk); #1 m_if.tready = 1'b0;
    @(negedge clk);
    cap_data = m_if.tdata; cap_user = m_if.tuser; cap_last = m_if.tlast;
    chk("bp_valid", m_if.tvalid, 1);
    chk("bp_s0_tready", s0_if.tready, 0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_valid", m_if.tvalid, 1);
      chk("bp_hold_data", m_if.tdata, cap_data);
      chk("bp_hold_user", m_if.tuser, cap_user);
      chk("bp_hold_last", m_if.tlast, cap_last);
      chk("bp_s0_tready", s0_if.tready, 0);
    end
    @(posedge clk); #1 m_if.tready = 1'b1;
    drain("bp_drain");

    // Source bubble on port 1 while port 0 waits (prio now favours port 1)
    base = nout;
    push_pkt(1, 4, 0); push_pkt(0, 2, 0);
    wait_out(base + 1, "bub_wait");
    @(posedge clk); #1 hold1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bub_s0_tready", s0_if.tready, 0);
    end
    @(posedge clk); #1 hold1 = 1'b0;
    drain("bub_drain");

    // Tag insertion with all-ones tuser and counter wrap
    do_reset();
    @(negedge clk);
    force dut.pkt_cnt1_q = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt1_q;
    push_pkt(1, 1, 1);
    drain("wrap_drain");
    chk("wrap_cnt1", pkt_cnt_1, 0);
    push_pkt(1, 1, 1); push_pkt(1, 1, 1);
    drain("tag_drain");
    chk("tag_cnt1", pkt_cnt_1, 2);
    chk("tag_cnt0", pkt_cnt_0, 0);

    // Reset mid-packet, then arbitration restarts with port 0 preferred
    push_pkt(0, 1, 0);
    drain("pre_rst_drain");
    base = nout;
    push_pkt(1, 4, 0);
    wait_out(base + 1, "mid_wait");
    @(posedge clk); #3 areset = 1'b1;
    #1;
    chk("mid_m_tvalid", m_if.tvalid, 0);
    chk("mid_s0_tready", s0_if.tready, 0);
    chk("mid_s1_tready", s1_if.tready, 0);
    chk("mid_cnt0", pkt_cnt_0, 0);
    chk("mid_cnt1", pkt_cnt_1, 0);
    q0.delete(); q1.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    push_pkt(0, 1, 0); push_pkt(1, 1, 0);
    drain("post_rst_drain");
    chk("post_cnt0", pkt_cnt_0, 1);
    chk("post_cnt1", pkt_cnt_1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
